usr_ctrl: RTL

USR_CTRL -- requirements
Module: usr_ctrl

---
 rtl/usr_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/usr_ctrl.sv
// Serial TX/RX controller that sequences an external 4-bit universal shift register.
// Each command loads the register, runs four shift cycles, then holds the result until it is consumed.
module usr_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic       ser_in,
  output logic       ser_out,
  output logic       ser_out_en,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [1:0] usr_select,
  output logic [3:0] usr_p_din,
  output logic       usr_s_left_din,
  output logic       usr_s_right_din,
  input  logic [3:0] usr_p_dout,
  output logic [1:0] dbg_state
);

  // Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready,
  // a response transfers on a cycle where rsp_valid && rsp_ready. Both ready/valid
  // outputs depend only on registered state, never on the partner's valid/ready.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_RIGHT = 2'd1;
  localparam logic [1:0] SEL_LEFT  = 2'd2;
  localparam logic [1:0] SEL_LOAD  = 2'd3;

  state_t     state;
  logic [1:0] bit_cnt;
  logic [1:0] op_q;
  logic [3:0] data_q;
  logic       is_rx;
  logic       msb_first;

  // op bit 1 selects RX, op bit 0 selects MSB-first ordering
  assign is_rx     = op_q[1];
  assign msb_first = op_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= 2'd0;
      op_q    <= 2'd0;
      data_q  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            bit_cnt <= 2'd0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cmd_ready       = (state == S_IDLE);
    rsp_valid       = (state == S_DONE);
    rsp_data        = usr_p_dout;
    usr_select      = SEL_HOLD;
    usr_p_din       = 4'd0;
    usr_s_left_din  = 1'b0;
    usr_s_right_din = 1'b0;
    ser_out         = 1'b0;
    ser_out_en      = 1'b0;
    case (state)
      S_LOAD: begin
        usr_select = SEL_LOAD;
        usr_p_din  = is_rx ? 4'd0 : data_q;
      end
      S_SHIFT: begin
        usr_select = msb_first ? SEL_LEFT : SEL_RIGHT;
        // Feeding the current value back keeps the register coherent if it samples p_din while shifting
        usr_p_din  = usr_p_dout;
        if (is_rx) begin
          if (msb_first) begin
            usr_s_left_din = ser_in;
          end else begin
            usr_s_right_din = ser_in;
          end
        end else begin
          ser_out_en = 1'b1;
          ser_out    = msb_first ? usr_p_dout[3] : usr_p_dout[0];
        end
      end
      default: begin
      end
    endcase
  end

  assign dbg_state = state;

endmodule
